// File: rtl/sram_wbuf_banked.sv
// rtl/sram_wbuf_banked.sv - sliced write-data buffer with read/write arbiter and read pipeline
// Define SRAM_WBUF_CLEAR_EN to zero every word during INIT before the buffer opens.
module sram_wbuf_banked #(
  parameter int DATA_WIDTH   = 518,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int SLICE_WIDTH  = 256,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4,
  localparam int NUM_SLICES  = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_SLICES-1:0] wr_slice_en,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [3:0]          LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    run, starve_hit, wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0]   slice_mask, rd_word;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata, mem_wmask;
  logic                    pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data;

`ifdef SRAM_WBUF_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
`endif

  // The last slice is narrower when DATA_WIDTH is not a multiple of SLICE_WIDTH.
  for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
    localparam int LO = s * SLICE_WIDTH;
    localparam int HI = ((s + 1) * SLICE_WIDTH < DATA_WIDTH) ? (s + 1) * SLICE_WIDTH : DATA_WIDTH;
    assign slice_mask[HI-1:LO] = {(HI - LO){wr_slice_en[s]}};
  end

  assign run         = (state_q == ST_RUN);
  assign starve_hit  = (starve_q == LIMIT);
  assign wr_ready    = run && wr_req && (!rd_req || starve_hit);
  assign rd_ready    = run && rd_req && !(wr_req && starve_hit);
  assign init_done   = run;
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign rd_word     = rd_in_range ? mem[rd_addr] : '0;

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_wmask = slice_mask;
`ifdef SRAM_WBUF_CLEAR_EN
    clr_d     = clr_q;
`endif
    if (state_q == ST_INIT) begin
`ifdef SRAM_WBUF_CLEAR_EN
      mem_we    = 1'b1;
      mem_waddr = clr_q;
      mem_wdata = '0;
      mem_wmask = '1;
      clr_d     = clr_q + 1'b1;
      if (clr_q == LAST_ADDR) state_d = ST_RUN;
`else
      state_d = ST_RUN;
`endif
    end else begin
      // Out-of-range writes are acknowledged but never reach the array.
      mem_we = wr_ready && wr_in_range;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!run || !wr_req || wr_ready) starve_d = '0;
    else if (!starve_hit)            starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    always_comb begin
      s1_valid_d = rd_ready;
      s1_data_d  = rd_ready ? rd_word : s1_data_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end
    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_ready;
    assign pipe_data  = rd_word;
  end

  always_comb begin
    rd_valid_d = pipe_valid;
    rd_data_d  = pipe_valid ? pipe_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef SRAM_WBUF_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
`ifdef SRAM_WBUF_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sram_wbuf_banked.sv
// tb/tb_sram_wbuf_banked.sv - randomized and directed bench for sram_wbuf_banked
// Instance a uses default parameters; instance b covers a partial slice, RD_LAT=2 and out-of-range addresses.
module tb_sram_wbuf_banked;
  localparam int DW = 518, DEPTH = 64, AW = 6, SW = 256, NS = 3, LAT = 1, SL = 4;
  localparam int BDW = 100;
`ifdef SRAM_WBUF_CLEAR_EN
  localparam int INIT_LEN = DEPTH;
`else
  localparam int INIT_LEN = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_req, rd_req, wr_ready, rd_ready, rd_valid, init_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [NS-1:0] wr_slice_en;

  logic           b_rst, b_wr_req, b_rd_req, b_wr_ready, b_rd_ready, b_rd_valid, b_init_done;
  logic [5:0]     b_wr_addr, b_rd_addr;
  logic [BDW-1:0] b_wr_data, b_rd_data;
  logic [1:0]     b_wr_slice_en;

  sram_wbuf_banked dut_a (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_slice_en(wr_slice_en), .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .init_done(init_done)
  );

  sram_wbuf_banked #(
    .DATA_WIDTH(BDW), .DEPTH(48), .ADDR_WIDTH(6), .SLICE_WIDTH(64), .RD_LAT(2), .STARVE_LIMIT(2)
  ) dut_b (
    .clk(clk), .rst(b_rst), .wr_req(b_wr_req), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_slice_en(b_wr_slice_en), .rd_req(b_rd_req), .rd_ready(b_rd_ready),
    .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .init_done(b_init_done)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s got=no grant in 50 cycles want=grant", nm);
  endtask

  function automatic logic [DW-1:0] smask(input logic [NS-1:0] en);
    logic [DW-1:0] m;
    logic [NS-1:0] sh;
    for (int i = 0; i < DW; i++) begin
      sh   = en >> (i / SW);
      m[i] = sh[0];
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Reference model: word array with known-bit masks, starvation count, queue of pending read returns.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic [DW-1:0] k;
  } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] m_mem   [DEPTH];
  logic [DW-1:0] m_known [DEPTH];
  logic [DW-1:0] m_hd, m_hk;
  int            m_k = -1, m_starve = 0, cyc = 0;
  logic          m_wr_g = 1'b0, m_rd_g = 1'b0;

  always @(negedge clk) begin : model
    logic          e_run, e_wr, e_rd, e_v;
    logic [DW-1:0] mk;
    cyc++;
    e_run = (m_k >= INIT_LEN);
    e_wr  = e_run && wr_req && (!rd_req || m_starve == SL);
    e_rd  = e_run && rd_req && !(wr_req && m_starve == SL);
    e_v   = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_v  = 1'b1;
      m_hd = rq[0].d;
      m_hk = rq[0].k;
      void'(rq.pop_front());
    end
    if (m_k >= 0) begin
      chk("wr_ready", wr_ready, e_wr);
      chk("rd_ready", rd_ready, e_rd);
      chk("init_done", init_done, e_run);
      chk("rd_valid", rd_valid, e_v);
      chk("rd_data", rd_data & m_hk, m_hd & m_hk);
    end
    m_wr_g = e_wr;
    m_rd_g = e_rd;
    if (e_wr) begin
      mk               = smask(wr_slice_en);
      m_mem[wr_addr]   = (m_mem[wr_addr] & ~mk) | (wr_data & mk);
      m_known[wr_addr] = m_known[wr_addr] | mk;
    end
    if (e_rd) rq.push_back('{due: cyc + LAT, d: m_mem[rd_addr], k: m_known[rd_addr]});
    if (!e_run || !wr_req || e_wr) m_starve = 0;
    else if (m_starve < SL)        m_starve++;
    if (rst) begin
      m_k = 0;
      rq.delete();
      m_hd = '0;
      m_hk = '1;
      m_starve = 0;
`ifdef SRAM_WBUF_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = '0;
        m_known[i] = '1;
      end
`endif
    end else if (m_k >= 0) begin
      m_k++;
    end
  end

  task automatic a_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NS-1:0] en);
    int n = 0;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_slice_en = en;
    do begin @(posedge clk); n++; end while (!m_wr_g && n < 50);
    if (!m_wr_g) tmo("write_grant");
    #1 wr_req = 1'b0;
  endtask

  task automatic a_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = a;
    do begin @(posedge clk); n++; end while (!m_rd_g && n < 50);
    if (!m_rd_g) tmo("read_grant");
    #1 rd_req = 1'b0;
    @(negedge clk);
    v = rd_valid;
    d = rd_data;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=time limit want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic          v;
    logic [DW-1:0] d, p3a, e;
    logic [7:0]    pb;
    logic [9:0]    wpat, rpat;
    logic [BDW-1:0] be;
    int            n, g;

    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
    wr_data = '0; wr_slice_en = '0;
    b_rst = 1'b1; b_wr_req = 1'b0; b_rd_req = 1'b0; b_wr_addr = '0; b_rd_addr = '0;
    b_wr_data = '0; b_wr_slice_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = '0;
    end
    m_hd = '0;
    m_hk = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_data", rd_data, '0);
    repeat (INIT_LEN - 1) @(negedge clk);
    chk("init_last_cycle_low", init_done, 1'b0);
    @(negedge clk);
    chk("init_rises", init_done, 1'b1);

`ifdef SRAM_WBUF_CLEAR_EN
    a_read(17, v, d);
    chk("clear_rd17_valid", v, 1'b1);
    chk("clear_rd17_data", d, '0);
`endif

    pb = 8'h3A;
    for (int i = 0; i < DW; i++) p3a[i] = pb[i % 8];
    a_write(5, p3a, '1);
    a_read(5, v, d);
    chk("rd5_valid_lat1", v, 1'b1);
    chk("rd5_data", d, p3a);

    a_write(9, '1, '1);
    a_write(9, '0, 3'b010);
    a_read(9, v, d);
    e = '1;
    e[511:256] = '0;
    chk("rd9_valid", v, 1'b1);
    chk("rd9_slice1_cleared", d, e);

    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 20; wr_data = rnd_word(); wr_slice_en = '1;
    rd_req = 1'b1; rd_addr = 21;
    wpat = '0;
    rpat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wpat = {wpat[8:0], wr_ready};
      rpat = {rpat[8:0], rd_ready};
    end
    chk("starve_wr_pattern", wpat, 10'b0000100001);
    chk("starve_rd_pattern", rpat, 10'b1111011110);
    @(posedge clk); #1;
    wr_req = 1'b0; rd_req = 1'b0;

    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 5;
    n = 0;
    g = 0;
    while (g < 3 && n < 50) begin
      @(posedge clk);
      n++;
      if (m_rd_g) g++;
    end
    if (g < 3) tmo("b2b_reads");
    #1 rd_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_init_done", init_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_rd_valid", rd_valid, 1'b0);
      chk("post_rst_rd_data", rd_data, '0);
      @(negedge clk);
    end

    @(posedge clk); #1;
    for (int c = 0; c < 1500; c++) begin
      if (!wr_req || m_wr_g) begin
        wr_req      = 1'($urandom_range(0, 1));
        wr_addr     = AW'($urandom_range(0, 7));
        wr_data     = rnd_word();
        wr_slice_en = NS'($urandom_range(0, 7));
      end
      if (!rd_req || m_rd_g) begin
        rd_req  = 1'($urandom_range(0, 1));
        rd_addr = AW'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (4) @(posedge clk);

    #1 b_rst = 1'b0;
    @(negedge clk);
    chk("b_init_c0", b_init_done, 1'b0);
    @(posedge clk); #1;
    b_wr_req = 1'b1; b_wr_addr = 3; b_wr_data = '1; b_wr_slice_en = 2'b11;
    @(negedge clk);
    chk("b_init_c1", b_init_done, 1'b1);
    chk("b_wr_ready_full", b_wr_ready, 1'b1);
    @(posedge clk); #1;
    b_wr_data = '0; b_wr_slice_en = 2'b10;
    @(negedge clk);
    chk("b_wr_ready_partial", b_wr_ready, 1'b1);
    @(posedge clk); #1;
    b_wr_addr = 50; b_wr_data = '1; b_wr_slice_en = 2'b11;
    @(negedge clk);
    chk("b_oor_write_ack", b_wr_ready, 1'b1);
    @(posedge clk); #1;
    b_wr_req = 1'b0; b_rd_req = 1'b1; b_rd_addr = 50;
    @(negedge clk);
    chk("b_rd_ready", b_rd_ready, 1'b1);
    @(posedge clk); #1;
    b_rd_addr = 3;
    @(negedge clk);
    chk("b_lat2_no_valid_yet", b_rd_valid, 1'b0);
    @(posedge clk); #1;
    b_rd_req = 1'b0;
    @(negedge clk);
    chk("b_oor_rd_valid", b_rd_valid, 1'b1);
    chk("b_oor_rd_data", b_rd_data, '0);
    be = '1;
    be[99:64] = '0;
    @(negedge clk);
    chk("b_rd3_valid", b_rd_valid, 1'b1);
    chk("b_rd3_data", b_rd_data, be);
    @(negedge clk);
    chk("b_idle_valid", b_rd_valid, 1'b0);
    chk("b_hold_data", b_rd_data, be);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
